// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width, baud arithmetic, parity helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Even parity: returns 1 when data plus parity bit hold an odd number of ones.
  function automatic logic parity_mismatch(input logic [UART_DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL sets the flops' reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and registered one-cycle status pulses.
// Define UART_RX_PARITY_EN to expect an even parity bit after data bit 7.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   busy
);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_W - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  logic                   rx_s;
  rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Next-state, counters and output pulses
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (rx_s) state_d = IDLE;   // start bit gone by mid-bit: treat as a glitch
          else      state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = AFTER_DATA;
          else                   state_d = DATA;
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = parity_mismatch(shift_q, par_q);
`endif
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
        else      state_d = BREAK;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit; follows UART_RX_PARITY_EN like the DUT.
module tb_uart_rx;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // Pin fall to visible rx_valid: mid-stop sample plus synchroniser and output register.
  localparam int LAT = (PAR_EN ? 10 : 9) * CPB + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_rx #(.CLK_FREQ_HZ(50_000_000), .BAUD(5_000_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  int         cyc = 0;
  int         ferr_cnt = 0, long_pulse = 0, perr_alone = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
  logic [7:0] got_data[$];
  int         got_cyc[$];
  logic       got_perr[$];

  int         errors = 0, checks = 0;
  int         start_cyc = 0, exp_ferr = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe pulses away from the active edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      got_data.push_back(rx_data);
      got_cyc.push_back(cyc);
      got_perr.push_back(parity_err);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (parity_err === 1'b1 && rx_valid !== 1'b1) perr_alone <= perr_alone + 1;
    if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_f) ||
        (parity_err === 1'b1 && prev_p))
      long_pulse <= long_pulse + 1;
    prev_v <= (rx_valid === 1'b1);
    prev_f <= (frame_err === 1'b1);
    prev_p <= (parity_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    got_data.delete();
    got_cyc.delete();
    got_perr.delete();
  endtask

  // Caller is positioned at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = p;
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Reference outcome of one frame, from the line rules alone
  task automatic check_frame(input string tag, input logic [7:0] d, input logic p, input logic stop);
    if (stop) begin
      check({tag, "_cnt"}, got_data.size(), 1);
      if (got_data.size() != 0) begin
        check({tag, "_data"}, got_data[0], d);
        check({tag, "_lat"}, got_cyc[0] - start_cyc, LAT);
        check({tag, "_perr"}, got_perr[0], PAR_EN ? ^{d, p} : 1'b0);
      end
      last_good = d;
    end else begin
      exp_ferr++;
      check({tag, "_cnt"}, got_data.size(), 0);
    end
    check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    check({tag, "_hold"}, rx_data, last_good);
    clear_obs();
  endtask

  initial begin
    logic [7:0] dir_bytes[4];
    logic [7:0] d;
    logic       p;
    logic [7:0] c3;

    // Reset with a toggling line
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
    end
    check("rst_data",  rx_data,    8'h00);
    check("rst_valid", rx_valid,   1'b0);
    check("rst_ferr",  frame_err,  1'b0);
    check("rst_perr",  parity_err, 1'b0);
    check("rst_busy",  busy,       1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_pulses", got_data.size(), 0);
    check("idle_ferr",   ferr_cnt,        0);
    check("idle_busy",   busy,            1'b0);
    clear_obs();

    // Directed bytes, back to back
    dir_bytes = '{8'hAA, 8'h55, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      p = ^dir_bytes[i];
      send_frame(dir_bytes[i], p, 1'b1);
      check_frame("dir", dir_bytes[i], p, 1'b1);
    end

    // Random bytes, random parity bit, random gaps (including none)
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2) * 7) @(negedge clk);
      send_frame(d, p, 1'b1);
      check_frame("rnd", d, p, 1'b1);
    end

    // Short low glitch
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_pulses",  got_data.size(), 0);
    check("glitch_ferr",    ferr_cnt, exp_ferr);

    // Framing error with the line held low afterwards
    send_frame(8'h3C, ^8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    check("ferr_busy_hi", busy, 1'b1);
    check_frame("ferr", 8'h3C, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("ferr_busy_lo", busy, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(8'h81, ^8'h81, 1'b1);
    check_frame("after_ferr", 8'h81, ^8'h81, 1'b1);

    // Reset during data bit 4, held until the frame has passed
    c3 = 8'hC3;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (CPB) @(negedge clk);
    end
    rx = c3[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (CPB - CPB / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx = c3[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = ^c3;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    last_good = 8'h00;
    check("midrst_pulses", got_data.size(), 0);
    check("midrst_ferr",   ferr_cnt, exp_ferr);
    check("midrst_data",   rx_data, last_good);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    check_frame("after_rst", 8'h5A, ^8'h5A, 1'b1);

`ifdef UART_RX_PARITY_EN
    // Even parity on 8'h07: parity bit 1 is correct, 0 is a mismatch
    repeat (5) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    check_frame("par_good", 8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    check_frame("par_bad", 8'h07, 1'b0, 1'b1);
`endif

    repeat (20) @(negedge clk);
    check("pulse_width", long_pulse, 0);
    check("perr_alone",  perr_alone, 0);
    check("final_busy",  busy,       1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream partner of uart_tx.
- Samples the serial line `rx`, recovers 8N1 frames, LSB first, and presents each byte with a single-cycle valid strobe.
- Sits between the board pin (or uart_tx `tx` in loopback) and the byte-consuming logic.
- Uses one clock domain; `rx` is asynchronous and is synchronised internally.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD, clocks per bit (integer division). Elaboration error if the value is less than 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  serial input; idle level is 1; asynchronous.
- rx_data  out  8  last received byte; holds its value until the next good frame.
- rx_valid  out  1  one-cycle pulse; rx_data is valid in that cycle.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 when the optional feature is compiled out.
- busy  out  1  high while any state other than IDLE is active.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; rx_data=8'h00; rx_valid=0; frame_err=0; parity_err=0; busy=0.
  - Bit and baud counters cleared; synchroniser flops set to 1.
  - Reset mid-frame aborts the frame with no pulses.
- Synchroniser: 2 flops on `rx` give `rx_s`. All decisions use `rx_s`, so there is 2 clocks of input latency.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on each sample event.
  - Half-bit point is CLKS_PER_BIT/2 (integer).
- States and transitions:
  - IDLE: on rx_s=0, clear the counter and go to START.
  - START: wait CLKS_PER_BIT/2 clocks, then sample.
    - rx_s=0 → DATA, bit index 0.
    - rx_s=1 → glitch; return to IDLE with no pulse.
  - DATA: sample every CLKS_PER_BIT clocks into shift register bit[index], LSB first. After index 7 → STOP, or PARITY when the feature is enabled.
  - PARITY (feature only): sample one bit after CLKS_PER_BIT clocks, then → STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rx_s=1 → next cycle: rx_data=shift register and rx_valid=1. If parity mismatched, parity_err=1 as well, and rx_data/rx_valid still update. Then → IDLE.
    - rx_s=0 → next cycle: frame_err=1; rx_data is unchanged and rx_valid stays 0. Then → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. This prevents a held-low line from re-triggering.
- Latency: rx_valid rises 1 clk after the mid-stop sample, which is about 9.5 bit times plus 3 clk after the falling edge of the start bit at the pin.
- Back-to-back frames: re-arming from IDLE happens in the cycle after STOP, so a start bit immediately following the stop bit is captured. The receiver tolerates ±2% baud mismatch.
- Outputs are registered; pulses never exceed one cycle.
- No back-pressure: the consumer must take rx_data when rx_valid is high. rx_data is held until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after data bit 7.
  - Even parity is expected: XOR of data and the parity bit must be 0.
  - parity_err pulses alongside rx_valid on mismatch.
  - Frame length is 11 bit times.
- Undefined:
  - No PARITY state; parity_err is constant 0.
  - Frame length is 10 bit times.

Decomposition:
- Shared package uart_pkg:
  - Enum rx_state_t: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constant UART_DATA_W=8.
  - Function clks_per_bit(clk_hz, baud).
  - uart_tx should also import this package.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with a reset value parameter (1 for rx). It is reusable for other asynchronous pins.

Test Plan (CLK_FREQ_HZ=50_000_000, BAUD=5_000_000, CLKS_PER_BIT=10):
- Reset check: hold rst=1 for 10 clk with rx toggling → all outputs 0 and busy=0; after release, rx held 1 → no pulse for 200 clk.
- Loopback: uart_tx (rst_n=~rst) sends 8'hAA, 8'h55, 8'h00, 8'hFF → four rx_valid pulses with matching rx_data in order, frame_err never set.
- Glitch: rx low for 3 clk, then high → no pulses; busy returns to 0 within 10 clk.
- Framing error: drive byte 8'h3C with stop bit 0 and rx held low for 30 clk → frame_err pulses once, rx_valid=0, rx_data keeps its previous value, busy stays high until rx=1; the next good 8'h81 is received.
- Reset mid-frame: assert rst during data bit 4 of 8'hC3 → no pulses; the next frame 8'h5A is received correctly.
- With UART_RX_PARITY_EN: send 8'h07 with parity 1 → rx_valid only; send 8'h07 with parity 0 → rx_valid and parity_err in the same cycle.
